// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and baud divisor rounding.
// Used by both the transmit and receive controllers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clocks per line bit, rounded to the nearest integer.
    function automatic int baud_div(input int clk_per, input int baud);
        return (clk_per + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/baud_tick.sv
// Free-running bit-period counter: counts 0..DIV-1 while enabled and pulses tick on the last count.
// Held at zero while disabled, so the first enabled cycle starts a fresh period.
module baud_tick #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tx_ctrl.sv
// UART transmitter: one byte per valid/ready handshake, framed as start, 8 data bits LSB first,
// optional parity and 1 or 2 stop bits. The line is driven from a flop fed by next-state.
module tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_PER   = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy
);

    localparam int DIV = baud_div(CLK_PER, BAUD);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    if (DIV < 2) begin : g_bad_div
        $error("tx_ctrl: baud divisor must be at least 2");
    end
    if (PARITY > 2 || PARITY < 0) begin : g_bad_parity
        $error("tx_ctrl: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("tx_ctrl: STOP_BITS must be 1 or 2");
    end

    // Handshake: a byte is taken at a rising edge where tx_valid && tx_ready;
    // tx_ready is a pure decode of IDLE, so upstream must hold tx_valid until then.
    uart_state_t state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  idx_q, idx_d;
    logic        par_q, par_d;
    logic        stop_q, stop_d;
    logic        tx_q, tx_d;
    logic        bit_end;

    baud_tick #(.DIV(DIV)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != IDLE),
        .tick (bit_end)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        par_d   = par_q;
        stop_d  = stop_q;
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    shreg_d = tx_data;
                    par_d   = (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
                    idx_d   = 3'd0;
                    stop_d  = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = (PARITY != PAR_NONE) ? PAR : STOP;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_q == LAST_STOP) begin
                        stop_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        stop_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered, so it changes exactly on bit boundaries.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PAR:     tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= 8'd0;
            idx_q   <= 3'd0;
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = (state_q == IDLE);
    assign tx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_tx_ctrl.sv
// Bench for tx_ctrl: five instances covering the parity/stop-bit variants and default baud,
// each frame checked cycle by cycle against a bit list built from the framing rules.
module tb_tx_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] d [5];
    logic       v [5];
    logic       t [5];
    logic       r [5];
    logic       b [5];

    int PAR_T [5] = '{0, 1, 2, 0, 0};
    int STP_T [5] = '{1, 1, 1, 2, 1};
    int DIV_T [5] = '{16, 16, 16, 16, 868};

    int n_checks = 0;
    int n_errors = 0;

    tx_ctrl #(.CLK_PER(1_600_000), .BAUD(100_000), .PARITY(0), .STOP_BITS(1)) u_p0s1 (
        .clk(clk), .rst(rst), .tx_data(d[0]), .tx_valid(v[0]),
        .tx_ready(r[0]), .tx(t[0]), .tx_busy(b[0]));
    tx_ctrl #(.CLK_PER(1_600_000), .BAUD(100_000), .PARITY(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst(rst), .tx_data(d[1]), .tx_valid(v[1]),
        .tx_ready(r[1]), .tx(t[1]), .tx_busy(b[1]));
    tx_ctrl #(.CLK_PER(1_600_000), .BAUD(100_000), .PARITY(2), .STOP_BITS(1)) u_even (
        .clk(clk), .rst(rst), .tx_data(d[2]), .tx_valid(v[2]),
        .tx_ready(r[2]), .tx(t[2]), .tx_busy(b[2]));
    tx_ctrl #(.CLK_PER(1_600_000), .BAUD(100_000), .PARITY(0), .STOP_BITS(2)) u_s2 (
        .clk(clk), .rst(rst), .tx_data(d[3]), .tx_valid(v[3]),
        .tx_ready(r[3]), .tx(t[3]), .tx_busy(b[3]));
    tx_ctrl u_def (
        .clk(clk), .rst(rst), .tx_data(d[4]), .tx_valid(v[4]),
        .tx_ready(r[4]), .tx(t[4]), .tx_busy(b[4]));

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("%s u%0d tx", tag, k), int'(t[k]), 1);
            check($sformatf("%s u%0d ready", tag, k), int'(r[k]), 1);
            check($sformatf("%s u%0d busy", tag, k), int'(b[k]), 0);
        end
    endtask

    // Present a byte on instance k once it is ready; returns just after the accepting edge.
    task automatic send(input int k, input logic [7:0] x);
        int n;
        @(negedge clk);
        n = 0;
        while (!r[k] && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!r[k]) check($sformatf("u%0d ready_timeout", k), 0, 1);
        d[k] = x;
        v[k] = 1'b1;
        @(posedge clk);
    endtask

    // Expected line: start 0, data LSB first, parity from popcount, stop 1s; each bit DIV cycles.
    task automatic check_frame(input int k, input logic [7:0] x, input bit hold,
                               input logic [7:0] mid);
        logic exp_q[$];
        logic exp_bit;
        int   ones, good, busyc, nb;
        exp_q.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(x[i]);
            ones += int'(x[i]);
        end
        if (PAR_T[k] == 2) exp_q.push_back(logic'(ones % 2));
        if (PAR_T[k] == 1) exp_q.push_back(logic'(1 - ones % 2));
        for (int s = 0; s < STP_T[k]; s++) exp_q.push_back(1'b1);
        nb = exp_q.size();
        busyc = 0;
        for (int bi = 0; bi < nb; bi++) begin
            exp_bit = exp_q.pop_front();
            good = 0;
            for (int c = 0; c < DIV_T[k]; c++) begin
                @(negedge clk);
                if (bi == 0 && c == 0 && !hold) v[k] = 1'b0;
                if (bi == 3 && c == 0) d[k] = mid;
                if (t[k] == exp_bit) good++;
                if (b[k] && !r[k]) busyc++;
            end
            check($sformatf("u%0d x%02h bit%0d cycles", k, x, bi), good, DIV_T[k]);
        end
        check($sformatf("u%0d x%02h busy_len", k, x), busyc, nb * DIV_T[k]);
        @(negedge clk);
        check($sformatf("u%0d x%02h after ready", k, x), int'(r[k]), 1);
        check($sformatf("u%0d x%02h after busy", k, x), int'(b[k]), 0);
        check($sformatf("u%0d x%02h after tx", k, x), int'(t[k]), 1);
    endtask

    initial begin
        logic [7:0] x;
        int k;
        for (int i = 0; i < 5; i++) begin
            d[i] = 8'h00;
            v[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_idle("in_reset");
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle("post_reset");
        end

        send(0, 8'hA5); check_frame(0, 8'hA5, 1'b0, 8'hA5);
        send(2, 8'h07); check_frame(2, 8'h07, 1'b0, 8'h07);
        send(1, 8'h07); check_frame(1, 8'h07, 1'b0, 8'h07);
        send(3, 8'h00); check_frame(3, 8'h00, 1'b0, 8'h00);

        // Back-to-back with valid held; data changes mid-frame to the second byte.
        send(0, 8'h55);
        check_frame(0, 8'h55, 1'b1, 8'hAA);
        @(posedge clk);
        check_frame(0, 8'hAA, 1'b0, 8'hAA);

        for (int n = 0; n < 12; n++) begin
            k = $urandom_range(0, 3);
            x = 8'($urandom_range(0, 255));
            send(k, x);
            check_frame(k, x, 1'b0, 8'($urandom_range(0, 255)));
        end

        // Abort mid-DATA: cycle 40 of the frame is data bit 1 of 8'h00.
        send(0, 8'h00);
        @(negedge clk);
        v[0] = 1'b0;
        repeat (39) @(negedge clk);
        check("pre_abort tx", int'(t[0]), 0);
        check("pre_abort busy", int'(b[0]), 1);
        #1 rst = 1'b1;
        #1;
        check("abort tx", int'(t[0]), 1);
        check("abort busy", int'(b[0]), 0);
        check("abort ready", int'(r[0]), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("after_abort");

        send(4, 8'h01); check_frame(4, 8'h01, 1'b0, 8'h01);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tx_ctrl.md
# tx_ctrl

UART transmitter: serialises one parallel byte per valid/ready handshake into an asynchronous frame on a single line. The frame is start bit, 8 data bits LSB first, optional parity, and 1 or 2 stop bits. It is the transmit-side counterpart of `rx_ctrl` in the UART path, shares the same `CLK_PER`/`BAUD` parameterisation, and drives the board TX pin directly.

## Interface
- `CLK_PER`, 100_000_000, system clock frequency in Hz.
- `BAUD`, 115200, line bit rate in bits/s.
- `PARITY`, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, number of stop bits: 1 or 2.

Ports (clock and reset first):
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `tx_data`  in  8  byte to send; sampled only on handshake.
- `tx_valid`  in  1  upstream has a byte on `tx_data`.
- `tx_ready`  out  1  block can accept a byte; high only in IDLE.
- `tx`  out  1  serial line; idles high; registered output.
- `tx_busy`  out  1  frame in progress (any state other than IDLE).

## Operation
- Divisor: `DIV = (CLK_PER + BAUD/2) / BAUD`, which rounds to nearest. Each line bit lasts exactly `DIV` clocks.
- Elaboration fails if `DIV < 2`, if `PARITY > 2`, or if `STOP_BITS` is not 1 or 2.
- Baud counter width is `$clog2(DIV)`. The counter runs 0..DIV-1, wraps to 0, and emits a one-cycle `bit_end` pulse at DIV-1. It is held at 0 in IDLE.
- States: IDLE, START, DATA, PAR, STOP.
- IDLE: when `tx_valid && tx_ready`, latch `tx_data` into the shift register and go to START.
  - Parity bit is precomputed at latch time: even parity = XOR of the data bits; odd parity = its inverse.
- START: `tx` = 0. On `bit_end`, go to DATA with bit index 0.
- DATA: `tx` = shift register LSB. On `bit_end`, shift right and increment the 3-bit index.
  - After index 7, go to PAR if `PARITY != 0`, otherwise to STOP.
- PAR: `tx` = parity bit. On `bit_end`, go to STOP.
- STOP: `tx` = 1. A stop counter counts `STOP_BITS` bit periods; on the final `bit_end`, go to IDLE.
- Changes on `tx_data` while busy are ignored. `tx_valid` while busy is not acknowledged; upstream must hold it.
- `tx` is driven from a flop computed from next-state, so the line never glitches.

## Timing
- Reset values: `tx` = 1, `tx_ready` = 1, `tx_busy` = 0, state IDLE, all counters 0.
- Reset asserted mid-frame aborts the frame immediately; `tx` returns high asynchronously.
- Handshake: acceptance happens at the rising edge where `tx_valid && tx_ready`. In the next cycle, `tx` = 0, `tx_ready` = 0 and `tx_busy` = 1.
- Frame length: `(1 + 8 + (PARITY!=0) + STOP_BITS) * DIV` cycles from the first start-bit cycle to the last stop-bit cycle.
- After the last stop cycle the block is in IDLE with `tx_ready` = 1 for at least one cycle.
- Back-to-back: with `tx_valid` held high, consecutive frames are separated by exactly one extra idle-high clock; there is no other gap.
- `tx_ready` is a pure decode of state (IDLE) and has no combinational path from `tx_valid`.

## Structure
- Shared package `uart_pkg`, used by both `rx_ctrl` and `tx_ctrl`:
  - `uart_state_t` enum (IDLE/START/DATA/PAR/STOP);
  - parity constants `PAR_NONE=0`, `PAR_ODD=1`, `PAR_EVEN=2`;
  - function `baud_div(clk_per, baud)` implementing the rounding rule.
- One sub-module, `baud_tick`: parameter `DIV`, ports `clk`, `rst`, `en`, `tick`. It is reused by `rx_ctrl` for mid-bit sampling. FSM, shift register and output flop stay in `tx_ctrl`.

## Test plan
Unless noted, the bench uses `CLK_PER`=1_600_000 and `BAUD`=100_000, so `DIV` = 16.
- Reset: hold `rst` = 1 for 5 cycles, then release → `tx` = 1, `tx_ready` = 1, `tx_busy` = 0 throughout. Assert `rst` mid-DATA → `tx` = 1 within the same cycle and state is IDLE.
- Single frame, `PARITY`=0, `STOP_BITS`=1, `tx_data`=8'hA5 → after handshake, `tx` shows 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 cycles (160 cycles total). `tx_ready` returns high on cycle 161.
- Parity, send 8'h07: even parity → bit = 1; odd parity → bit = 0. Frame is 176 cycles.
- `STOP_BITS`=2, send 8'h00 → stop-high period is 32 cycles; `tx_busy` is high for 192 cycles.
- Back-to-back: `tx_valid` held high with 8'h55 then 8'hAA → exactly one extra high cycle between the frames. `tx_data` changed mid-frame does not corrupt the current frame.
- Default parameters (`CLK_PER`=100 MHz, `BAUD`=115200) → `DIV` = 868; one bit period is measured at 868 cycles.
